// File: rtl/fetch_seq.sv
// fetch_seq: fetch/execute sequencer for the 8-bit microprocessor.
// Owns the program counter, fetches a two-byte instruction (opcode byte, then
// address byte) into the instruction register, launches execute and waits for
// it to finish. A memory read that goes unanswered for TIMEOUT cycles parks the
// sequencer in FAULT with a sticky bus_err until reset.
module fetch_seq #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int RST_PC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              mem_ack,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] pc,
  output logic              LOAD_IRU,
  output logic              LOAD_IRL,
  output logic              exec_go,
  output logic              busy,
  output logic              bus_err
);

  // Wait counter must hold values 0..TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RST_PC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_U    = 3'd1,
    S_LD_U    = 3'd2,
    S_RD_L    = 3'd3,
    S_LD_L    = 3'd4,
    S_EXEC    = 3'd5,
    S_WAIT_EX = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_rd_q, mem_rd_d;
  logic              load_iru_q, load_iru_d;
  logic              load_irl_q, load_irl_d;
  logic              exec_go_q, exec_go_d;
  logic              busy_q, busy_d;

  // Next-state, program counter and wait-counter logic; outputs are decoded
  // from the next state so the registered outputs track the current state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_U;
          wait_d  = '0;
        end
      end
      S_RD_U, S_RD_L: begin
        if (mem_ack) begin
          state_d = (state_q == S_RD_U) ? S_LD_U : S_LD_L;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_FAULT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_LD_U: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_RD_L;
        wait_d  = '0;
      end
      S_LD_L: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WAIT_EX;
      end
      S_WAIT_EX: begin
        if (exec_done) begin
          if (pc_load) begin
            pc_d = pc_in;
          end
          // halt is only honoured here, at the instruction boundary.
          state_d = halt_req ? S_IDLE : S_RD_U;
          wait_d  = '0;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_rd_d   = (state_d == S_RD_U) || (state_d == S_RD_L);
    load_iru_d = (state_d == S_LD_U);
    load_irl_d = (state_d == S_LD_L);
    exec_go_d  = (state_d == S_EXEC);
    busy_d     = (state_d != S_IDLE) && (state_d != S_FAULT);
  end

  // Single state register for the sequencer and its Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RESET;
      wait_q     <= '0;
      bus_err_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      load_iru_q <= 1'b0;
      load_irl_q <= 1'b0;
      exec_go_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_q     <= wait_d;
      bus_err_q  <= bus_err_d;
      mem_rd_q   <= mem_rd_d;
      load_iru_q <= load_iru_d;
      load_irl_q <= load_irl_d;
      exec_go_q  <= exec_go_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign pc       = pc_q;
  assign LOAD_IRU = load_iru_q;
  assign LOAD_IRL = load_irl_q;
  assign exec_go  = exec_go_q;
  assign busy     = busy_q;
  assign bus_err  = bus_err_q;

endmodule
